// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant, index and valid.
// Optional forced rotation after HOLD_MAX grant cycles is enabled by defining RR_TIMEOUT_EN.
module rr_arbiter8 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit of r in the circular order p, p+1, ..., p+7 (mod 8).
  function automatic pick_t rr_pick(input logic [7:0] r, input logic [2:0] p);
    pick_t      res;
    logic [7:0] rot;
    rot       = 8'({r, r} >> p);
    res.found = |r;
    res.idx   = p;
    for (int k = 7; k >= 0; k--) begin
      if (rot[k]) res.idx = p + 3'(k);
    end
    return res;
  endfunction

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] idx_nxt;
  logic       valid_nxt;
  logic       take;
  logic [2:0] winner;
  logic [7:0] gnt_cur;
  logic [7:0] others;
  pick_t      pick_all;
  pick_t      pick_oth;
  logic       hold_expired;

  assign gnt_cur  = 8'b1 << gnt_idx;
  assign others   = req & ~gnt_cur;
  assign pick_all = rr_pick(req, ptr);
  assign pick_oth = rr_pick(others, ptr);

`ifdef RR_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] hold_cnt, hold_cnt_nxt;

  assign hold_expired = (hold_cnt == HOLD_LAST);
`else
  assign hold_expired = 1'b0;
`endif

  // NOTE: every variable assigned here gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = gnt_idx;
    valid_nxt = gnt_valid;
    take      = 1'b0;
    winner    = gnt_idx;

    unique case (state)
      IDLE: begin
        if (en && pick_all.found) begin
          take   = 1'b1;
          winner = pick_all.idx;
        end
      end
      GRANT: begin
        if (!en) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end else if (!req[gnt_idx]) begin
          // Release: hand over without an idle gap if anyone else is waiting.
          if (pick_oth.found) begin
            take   = 1'b1;
            winner = pick_oth.idx;
          end else begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
          end
        end else if (hold_expired && pick_oth.found) begin
          take   = 1'b1;
          winner = pick_oth.idx;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase

    if (take) begin
      state_nxt = GRANT;
      valid_nxt = 1'b1;
      idx_nxt   = winner;
      ptr_nxt   = winner + 3'd1;
    end
  end

`ifdef RR_TIMEOUT_EN
  always_comb begin
    hold_cnt_nxt = hold_cnt;
    if (take) begin
      hold_cnt_nxt = 8'd0;
    end else if (state == GRANT && state_nxt == GRANT && !hold_expired) begin
      hold_cnt_nxt = hold_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hold_cnt <= 8'd0;
    else     hold_cnt <= hold_cnt_nxt;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      gnt       <= 8'h00;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= valid_nxt;
      gnt       <= valid_nxt ? (8'b1 << idx_nxt) : 8'h00;
    end
  end

  a_hold_max_range: assert property (@(posedge clk) (HOLD_MAX >= 2) && (HOLD_MAX <= 255));
  a_gnt_onehot:     assert property (@(posedge clk) $onehot0(gnt));
  a_gnt_decode:     assert property (@(posedge clk) gnt == (gnt_valid ? (8'b1 << gnt_idx) : 8'h00));

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed vector table, hold/timeout sequence,
// and a randomised invariant sweep.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int total = 0;
  int bad   = 0;

  rr_arbiter8 #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic r, input logic e, input logic [7:0] q,
                              input logic [7:0] g, input logic [2:0] i, input logic v);
    vec_t t;
    t.rst = r; t.en = e; t.req = q; t.gnt = g; t.idx = i; t.valid = v;
    vecs.push_back(t);
  endfunction

  logic [7:0] exp_g;
  logic [7:0] prev_req;
  logic       prev_en;

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    req = 8'hFF;

    // Reset held two cycles with all requests up.
    add(1, 1, 8'hFF, 8'h00, 3'd0, 0);
    add(1, 1, 8'hFF, 8'h00, 3'd0, 0);
    add(0, 1, 8'hFF, 8'h01, 3'd0, 1);
    // Rotation: each grantee drops its request for one cycle.
    add(0, 1, 8'hFE, 8'h02, 3'd1, 1);
    add(0, 1, 8'hFD, 8'h04, 3'd2, 1);
    add(0, 1, 8'hFB, 8'h08, 3'd3, 1);
    add(0, 1, 8'hF7, 8'h10, 3'd4, 1);
    add(0, 1, 8'hEF, 8'h20, 3'd5, 1);
    add(0, 1, 8'hDF, 8'h40, 3'd6, 1);
    add(0, 1, 8'hBF, 8'h80, 3'd7, 1);
    add(0, 1, 8'h7F, 8'h01, 3'd0, 1);
    add(0, 1, 8'hFF, 8'h01, 3'd0, 1);
    // Wrap search from ptr=6.
    add(0, 1, 8'h20, 8'h20, 3'd5, 1);
    add(0, 1, 8'h09, 8'h01, 3'd0, 1);
    add(0, 1, 8'h08, 8'h08, 3'd3, 1);
    // Revoke, idle with en low, regrant.
    add(0, 0, 8'h08, 8'h00, 3'd3, 0);
    add(0, 0, 8'hFF, 8'h00, 3'd3, 0);
    add(0, 1, 8'h08, 8'h08, 3'd3, 1);
    add(0, 1, 8'h00, 8'h00, 3'd3, 0);
    add(0, 1, 8'h00, 8'h00, 3'd3, 0);
    // Reset mid-grant, then first grant searches from requester 0.
    add(0, 1, 8'h10, 8'h10, 3'd4, 1);
    add(1, 1, 8'h10, 8'h00, 3'd0, 0);
    add(0, 1, 8'h82, 8'h02, 3'd1, 1);
    // Single requester regranted across the 7->0 pointer wrap.
    add(0, 1, 8'h00, 8'h00, 3'd1, 0);
    add(0, 1, 8'h80, 8'h80, 3'd7, 1);
    add(0, 1, 8'h00, 8'h00, 3'd7, 0);
    add(0, 1, 8'h80, 8'h80, 3'd7, 1);
    add(0, 1, 8'h00, 8'h00, 3'd7, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      en  = vecs[i].en;
      req = vecs[i].req;
      tick();
      check($sformatf("vec%0d gnt", i),   gnt,                    vecs[i].gnt);
      check($sformatf("vec%0d idx", i),   {5'b0, gnt_idx},        {5'b0, vecs[i].idx});
      check($sformatf("vec%0d valid", i), {7'b0, gnt_valid},      {7'b0, vecs[i].valid});
    end

    // Two persistent requesters: held forever by default, alternating every 4 with timeout.
    req = 8'h03;
    for (int i = 0; i < 20; i++) begin
      tick();
`ifdef RR_TIMEOUT_EN
      exp_g = ((i / 4) % 2 == 1) ? 8'h02 : 8'h01;
`else
      exp_g = 8'h01;
`endif
      check($sformatf("hold2 c%0d gnt", i), gnt, exp_g);
    end

    // Lone requester keeps the grant indefinitely in either build.
    req = 8'h01;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("hold1 c%0d gnt", i), gnt, 8'h01);
    end

    // Random sweep: structural invariants and grant only to a requester seen at the edge.
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      req = 8'($urandom);
      if ($urandom_range(0, 3) == 0) req = req & 8'($urandom);
      prev_req = req;
      prev_en  = en;
      tick();
      check($sformatf("rnd%0d decode", i), gnt, gnt_valid ? (8'b1 << gnt_idx) : 8'h00);
      if (gnt_valid) begin
        check($sformatf("rnd%0d owner", i), {6'b0, prev_en, prev_req[gnt_idx]}, 8'h03);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
